// File: rtl/ac97_pcm_unpacker_pkg.sv
// ac97_pcm_unpacker_pkg: shared AC-link slot constants and legal PCM sample widths
package ac97_pcm_unpacker_pkg;
  localparam int AC97_SLOT_W = 20;
  localparam int PCM_L = 3;
  localparam int PCM_R = 4;
  typedef enum int {SB_8 = 8, SB_16 = 16, SB_32 = 32} sample_bits_e;
endpackage

// File: rtl/ac97_pcm_unpacker_sample_fmt.sv
// ac97_sample_fmt: combinational packed-sample to 20-bit slot formatter (ports: sample in, slot out)
module ac97_sample_fmt
  import ac97_pcm_unpacker_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int SIGNED_8 = 0
) (
  input  logic [SAMPLE_BITS-1:0] sample,
  output logic [AC97_SLOT_W-1:0] slot
);
  if (SAMPLE_BITS == SB_8) begin : g_8
    // unsigned 8-bit PCM is offset binary; flipping the MSB yields two's complement
    assign slot = {(SIGNED_8 != 0) ? sample[7] : ~sample[7], sample[6:0], 12'b0};
  end else if (SAMPLE_BITS == SB_32) begin : g_32
    assign slot = sample[31:12];
  end else begin : g_16
    assign slot = {sample, 4'b0};
  end
endmodule

// File: rtl/ac97_pcm_unpacker.sv
// ac97_pcm_unpacker: unpacks DMA FIFO words into per-frame PCM slot 3/4 data.
// Ports: ac97_bitclk/ac97_reset_b clock and async active-low reset; ac97_strobe frame pulse;
// enable playback; flush drops rest of word; fifo_data/fifo_empty FWFT FIFO head; fifo_pop;
// slot3/slot3_valid and slot4/slot4_valid registered slot outputs.
// Optional macro AC97_UNPACK_UNDERRUN_CNT_EN adds saturating underrun_count[15:0].
module ac97_pcm_unpacker
  import ac97_pcm_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SAMPLE_BITS = 16,
  parameter int NUM_CH = 2,
  parameter int SIGNED_8 = 0
) (
  input  logic                   ac97_bitclk,
  input  logic                   ac97_reset_b,
  input  logic                   ac97_strobe,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  output logic [AC97_SLOT_W-1:0] slot3,
  output logic                   slot3_valid,
  output logic [AC97_SLOT_W-1:0] slot4,
  output logic                   slot4_valid
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_count
`endif
);
  localparam int SPW = DATA_WIDTH / SAMPLE_BITS;
  localparam int FPW = SPW / NUM_CH;
  localparam int IW = FPW > 1 ? $clog2(FPW) : 1;
  logic [FPW-1:0][NUM_CH-1:0][SAMPLE_BITS-1:0] frames;
  logic [IW-1:0] idx;
  logic [AC97_SLOT_W-1:0] fmt_l, fmt_r;
  logic last, emit;
  // little-endian packing: frame f, channel c sits at sample f*NUM_CH+c
  assign frames = fifo_data;
  assign last = idx == IW'(FPW - 1);
  assign emit = ac97_strobe & enable & ~fifo_empty & ~flush;
  // flush discards a partially consumed word only; an untouched word stays queued
  assign fifo_pop = flush ? (idx != '0) & ~fifo_empty : emit & last;
  ac97_sample_fmt #(.SAMPLE_BITS(SAMPLE_BITS), .SIGNED_8(SIGNED_8)) u_fmt_l (
    .sample(frames[idx][0]),
    .slot  (fmt_l)
  );
  if (NUM_CH > 1) begin : g_stereo
    ac97_sample_fmt #(.SAMPLE_BITS(SAMPLE_BITS), .SIGNED_8(SIGNED_8)) u_fmt_r (
      .sample(frames[idx][NUM_CH-1]),
      .slot  (fmt_r)
    );
  end else begin : g_mono
    assign fmt_r = fmt_l;
  end
  always_ff @(posedge ac97_bitclk or negedge ac97_reset_b) begin
    if (!ac97_reset_b) begin
      idx <= '0;
      slot3 <= '0;
      slot4 <= '0;
      slot3_valid <= 1'b0;
      slot4_valid <= 1'b0;
    end else begin
      if (flush) idx <= '0;
      else if (emit) idx <= last ? '0 : idx + 1'b1;
      if (emit) begin
        slot3 <= fmt_l;
        slot4 <= fmt_r;
      end
      if (ac97_strobe) begin
        slot3_valid <= emit;
        slot4_valid <= emit;
      end
    end
  end
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
  always_ff @(posedge ac97_bitclk or negedge ac97_reset_b) begin
    if (!ac97_reset_b) underrun_count <= '0;
    else if (ac97_strobe & enable & fifo_empty & ~flush & (underrun_count != 16'hFFFF))
      underrun_count <= underrun_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ac97_pcm_unpacker.sv
// tb_ac97_pcm_unpacker: directed self-checking bench for default and 8-bit mono unpackers
module tb_ac97_pcm_unpacker;
  logic clk = 1'b0;
  logic rst_n, strobe, enable, flush;
  logic [63:0] data_a, data_b;
  logic empty_a, empty_b;
  logic pop_a, pop_b, v3_a, v4_a, v3_b, v4_b;
  logic [19:0] s3_a, s4_a, s3_b, s4_b;
  int checks = 0;
  int errors = 0;
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  ac97_pcm_unpacker u_dut (
    .ac97_bitclk(clk), .ac97_reset_b(rst_n), .ac97_strobe(strobe), .enable(enable),
    .flush(flush), .fifo_data(data_a), .fifo_empty(empty_a), .fifo_pop(pop_a),
    .slot3(s3_a), .slot3_valid(v3_a), .slot4(s4_a), .slot4_valid(v4_a)
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
    , .underrun_count(cnt_a)
`endif
  );

  ac97_pcm_unpacker #(.DATA_WIDTH(64), .SAMPLE_BITS(8), .NUM_CH(1), .SIGNED_8(0)) u_dut8 (
    .ac97_bitclk(clk), .ac97_reset_b(rst_n), .ac97_strobe(strobe), .enable(enable),
    .flush(flush), .fifo_data(data_b), .fifo_empty(empty_b), .fifo_pop(pop_b),
    .slot3(s3_b), .slot3_valid(v3_b), .slot4(s4_b), .slot4_valid(v4_b)
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
    , .underrun_count(cnt_b)
`endif
  );

  // one frame strobe; pops sampled mid-cycle, a popped single-word FIFO goes empty
  task automatic do_strobe(input logic f, output logic pa, output logic pb);
    @(negedge clk);
    strobe = 1'b1;
    flush = f;
    #1;
    pa = pop_a;
    pb = pop_b;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    flush = 1'b0;
    if (pa) empty_a = 1'b1;
    if (pb) empty_b = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (s3_a !== 20'h0 || s4_a !== 20'h0) begin errors++; $display("FAIL reset_slots got %h/%h exp 0/0", s3_a, s4_a); end
    checks++; if ({v3_a, v4_a, v3_b, v4_b} !== 4'b0) begin errors++; $display("FAIL reset_valid got %b exp 0000", {v3_a, v4_a, v3_b, v4_b}); end
    checks++; if ({pop_a, pop_b} !== 2'b0) begin errors++; $display("FAIL reset_pop got %b exp 00", {pop_a, pop_b}); end
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
    checks++; if (cnt_a !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt_a); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stereo16();
    logic pa, pb;
    data_a = 64'h4444_3333_2222_1111;
    empty_a = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if (pa !== 1'b0) begin errors++; $display("FAIL st_pop1 got %b exp 0", pa); end
    checks++; if (s3_a !== 20'h11110 || s4_a !== 20'h22220) begin errors++; $display("FAIL st_frame0 got %h/%h exp 11110/22220", s3_a, s4_a); end
    checks++; if ({v3_a, v4_a} !== 2'b11) begin errors++; $display("FAIL st_valid0 got %b exp 11", {v3_a, v4_a}); end
    do_strobe(1'b0, pa, pb);
    checks++; if (pa !== 1'b1) begin errors++; $display("FAIL st_pop2 got %b exp 1", pa); end
    checks++; if (s3_a !== 20'h33330 || s4_a !== 20'h44440) begin errors++; $display("FAIL st_frame1 got %h/%h exp 33330/44440", s3_a, s4_a); end
    for (int i = 0; i < 2; i++) begin
      do_strobe(1'b0, pa, pb);
      checks++; if ({v3_a, v4_a, pa} !== 3'b000) begin errors++; $display("FAIL st_empty%0d valid/pop got %b exp 000", i, {v3_a, v4_a, pa}); end
      checks++; if (s3_a !== 20'h33330) begin errors++; $display("FAIL st_hold%0d got %h exp 33330", i, s3_a); end
    end
  endtask

  task automatic test_mono8();
    logic pa, pb;
    logic [19:0] exp8 [8];
    exp8 = '{20'h80000, 20'h00000, 20'h80000, 20'h7F000, 20'h81000, 20'h80000, 20'hFF000, 20'h00000};
    data_b = 64'h807F_0001_FF00_8000;
    empty_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_strobe(1'b0, pa, pb);
      checks++; if (s3_b !== exp8[i] || s4_b !== exp8[i]) begin errors++; $display("FAIL m8_frame%0d got %h/%h exp %h", i, s3_b, s4_b, exp8[i]); end
      checks++; if ({v3_b, v4_b, pb} !== {2'b11, i == 7}) begin errors++; $display("FAIL m8_ctl%0d got %b exp %b", i, {v3_b, v4_b, pb}, {2'b11, i == 7}); end
    end
  endtask

  task automatic test_underrun();
    logic pa, pb;
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
    logic [15:0] c0;
    c0 = cnt_a;
`endif
    empty_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_strobe(1'b0, pa, pb);
      checks++; if ({v3_a, v4_a, pa} !== 3'b000) begin errors++; $display("FAIL ur_%0d valid/pop got %b exp 000", i, {v3_a, v4_a, pa}); end
    end
`ifdef AC97_UNPACK_UNDERRUN_CNT_EN
    checks++; if (cnt_a - c0 !== 16'd3) begin errors++; $display("FAIL ur_count got %0d exp 3", cnt_a - c0); end
`endif
    data_a = 64'h8888_7777_6666_5555;
    empty_a = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if ({v3_a, v4_a, pa} !== 3'b110) begin errors++; $display("FAIL ur_refill_ctl got %b exp 110", {v3_a, v4_a, pa}); end
    checks++; if (s3_a !== 20'h55550 || s4_a !== 20'h66660) begin errors++; $display("FAIL ur_refill got %h/%h exp 55550/66660", s3_a, s4_a); end
  endtask

  task automatic test_flush();
    logic pa, pb;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (pop_a !== 1'b1) begin errors++; $display("FAIL fl_partial_pop got %b exp 1", pop_a); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    empty_a = 1'b1;
    data_a = 64'hDDDD_CCCC_BBBB_AAAA;
    empty_a = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (pop_a !== 1'b0) begin errors++; $display("FAIL fl_idle_pop got %b exp 0", pop_a); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if (s3_a !== 20'hAAAA0 || s4_a !== 20'hBBBB0 || pa !== 1'b0) begin errors++; $display("FAIL fl_next got %h/%h pop %b exp AAAA0/BBBB0 pop 0", s3_a, s4_a, pa); end
    do_strobe(1'b1, pa, pb);
    checks++; if ({v3_a, v4_a, pa} !== 3'b001) begin errors++; $display("FAIL fl_strobe_ctl got %b exp 001", {v3_a, v4_a, pa}); end
    checks++; if (s3_a !== 20'hAAAA0) begin errors++; $display("FAIL fl_strobe_hold got %h exp AAAA0", s3_a); end
  endtask

  task automatic test_enable();
    logic pa, pb;
    data_a = 64'h4000_3000_2000_1000;
    empty_a = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if (s3_a !== 20'h10000 || s4_a !== 20'h20000) begin errors++; $display("FAIL en_first got %h/%h exp 10000/20000", s3_a, s4_a); end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_strobe(1'b0, pa, pb);
      checks++; if ({v3_a, v4_a, pa} !== 3'b000) begin errors++; $display("FAIL en_off%0d got %b exp 000", i, {v3_a, v4_a, pa}); end
    end
    enable = 1'b1;
    do_strobe(1'b0, pa, pb);
    checks++; if (s3_a !== 20'h30000 || s4_a !== 20'h40000 || {v3_a, pa} !== 2'b11) begin errors++; $display("FAIL en_resume got %h/%h v/pop %b exp 30000/40000 11", s3_a, s4_a, {v3_a, pa}); end
  endtask

  task automatic test_reset_mid();
    logic pa, pb;
    data_a = 64'h0F0F_0E0E_0D0D_0C0C;
    empty_a = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if (s3_a !== 20'h0C0C0) begin errors++; $display("FAIL rm_pre got %h exp 0C0C0", s3_a); end
    #2;
    rst_n = 1'b0;
    empty_a = 1'b1;
    #1;
    checks++; if (s3_a !== 20'h0 || s4_a !== 20'h0 || {v3_a, v4_a} !== 2'b00) begin errors++; $display("FAIL rm_async got %h/%h %b exp 0/0 00", s3_a, s4_a, {v3_a, v4_a}); end
    @(negedge clk);
    rst_n = 1'b1;
    data_a = 64'h0404_0303_0202_0101;
    empty_a = 1'b0;
    do_strobe(1'b0, pa, pb);
    checks++; if (s3_a !== 20'h01010 || s4_a !== 20'h02020 || pa !== 1'b0) begin errors++; $display("FAIL rm_frame0 got %h/%h pop %b exp 01010/02020 pop 0", s3_a, s4_a, pa); end
  endtask

  initial begin
    rst_n = 1'b0;
    strobe = 1'b0;
    enable = 1'b1;
    flush = 1'b0;
    data_a = '0;
    data_b = '0;
    empty_a = 1'b1;
    empty_b = 1'b1;
    test_reset();
    test_stereo16();
    test_mono8();
    test_underrun();
    test_flush();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
